// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//   Control stage around the PUF challenge LFSR. Seeds and steps the LFSR, presents
//   each LFSR state as a challenge to the RO-pair compare array, collects one
//   response bit per challenge and packs RESP_BITS bits (first bit in MSB) into a
//   word handed downstream with valid/ready. Flags timeouts, an illegal
//   (lock-up) seed and LFSR sequence wrap.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, seed         run request (ignored while busy) and LFSR seed
//   busy, done          run in progress / 1-cycle end-of-run pulse
//   err, wrap           sticky status, cleared by the next accepted start
//   lfsr_en             LFSR enable
//   lfsr_seed_dv        LFSR seed load strobe
//   lfsr_seed           latched seed to the LFSR
//   lfsr_out            current LFSR state
//   lfsr_done           LFSR state equals its seed
//   chal, chal_valid    challenge to the RO array and its 1-cycle strobe
//   resp_valid, resp_bit  response strobe and bit from the RO array
//   resp_word, resp_word_valid, resp_word_ready  packed output handshake
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// SEED  | load latched seed into the LFSR
// STEP  | advance the LFSR one state
// ISSUE | strobe the challenge, note wrap if the LFSR is back at its seed
// WAIT  | wait for the response bit, bounded by EVAL_TIMEOUT cycles
// OUT   | present the packed word until accepted
// DONE  | one-cycle done pulse

module puf_challenge_sequencer #(
  parameter int WIDTH        = 8,
  parameter int RESP_BITS    = 32,
  parameter int EVAL_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 wrap,
  output logic                 lfsr_en,
  output logic                 lfsr_seed_dv,
  output logic [WIDTH-1:0]     lfsr_seed,
  input  logic [WIDTH-1:0]     lfsr_out,
  input  logic                 lfsr_done,
  output logic [WIDTH-1:0]     chal,
  output logic                 chal_valid,
  input  logic                 resp_valid,
  input  logic                 resp_bit,
  output logic [RESP_BITS-1:0] resp_word,
  output logic                 resp_word_valid,
  input  logic                 resp_word_ready
);

  localparam int BCW = $clog2(RESP_BITS + 1);
  localparam int TCW = $clog2(EVAL_TIMEOUT + 1);
  localparam int SRW = RESP_BITS - 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(RESP_BITS - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(EVAL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_STEP,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t         state;
  logic [BCW-1:0] bit_cnt;
  logic [TCW-1:0] to_cnt;
  // Only the first RESP_BITS-1 bits need holding; the last bit goes straight
  // into resp_word together with them.
  logic [SRW-1:0] sr;

  // The LFSR has already advanced when ISSUE is entered and is frozen through
  // WAIT, so the challenge is taken directly from its output.
  assign chal = ((state == S_ISSUE) || (state == S_WAIT)) ? lfsr_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      wrap            <= 1'b0;
      lfsr_en         <= 1'b0;
      lfsr_seed_dv    <= 1'b0;
      lfsr_seed       <= '0;
      chal_valid      <= 1'b0;
      resp_word       <= '0;
      resp_word_valid <= 1'b0;
      bit_cnt         <= '0;
      to_cnt          <= '0;
      sr              <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr_seed <= seed;
            err       <= 1'b0;
            wrap      <= 1'b0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            sr        <= '0;
            // All-ones is the XNOR LFSR lock-up state: reject without stepping.
            if (&seed) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy         <= 1'b1;
              lfsr_en      <= 1'b1;
              lfsr_seed_dv <= 1'b1;
              state        <= S_SEED;
            end
          end
        end
        S_SEED: begin
          lfsr_seed_dv <= 1'b0;
          state        <= S_STEP;
        end
        S_STEP: begin
          lfsr_en    <= 1'b0;
          chal_valid <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          chal_valid <= 1'b0;
          to_cnt     <= '0;
          if (lfsr_done) wrap <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the final timeout cycle still counts.
          if (resp_valid) begin
            sr      <= SRW'({sr, resp_bit});
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BIT_LAST) begin
              resp_word       <= {sr, resp_bit};
              resp_word_valid <= 1'b1;
              state           <= S_OUT;
            end else begin
              lfsr_en <= 1'b1;
              state   <= S_STEP;
            end
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
        S_OUT: begin
          if (resp_word_ready) begin
            resp_word_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
